// File: rtl/imm_ext_pipe_pkg.sv
// Shared definitions for the immediate extender: select encodings and
// the illegal-select predicate.
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  // Codes 110 and 111 are unassigned.
  function automatic logic is_illegal_immsrc(input logic [2:0] immsrc);
    return immsrc[2] & immsrc[1];
  endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for the immediate extender: request side, result side,
// flush and the illegal-select counter.
interface imm_ext_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:7]       in_instr;
  logic [2:0]        in_immsrc;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_immext;
  logic              out_illegal;
  logic [TAG_W-1:0]  out_tag;
  logic [CNT_W-1:0]  illegal_cnt;

  // The block itself
  modport slave (
    input  flush, in_valid, in_instr, in_immsrc, in_tag, out_ready,
    output in_ready, out_valid, out_immext, out_illegal, out_tag, illegal_cnt
  );

  // Upstream/downstream environment
  modport master (
    output flush, in_valid, in_instr, in_immsrc, in_tag, out_ready,
    input  in_ready, out_valid, out_immext, out_illegal, out_tag, illegal_cnt
  );
endinterface

// File: rtl/imm_ext_pipe_decode.sv
// Combinational immediate decode: instr[31:7] + select -> XLEN immediate.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  logic [2:0]      i_immsrc,
  output logic [XLEN-1:0] o_immext,
  output logic            o_illegal
);

  logic        w_s;
  logic [31:0] w_u;

  assign w_s = i_instr[31];
  // U-type built at 32 bits; the signed cast below widens it from bit 31
  // when XLEN is 64 and is a no-op at XLEN 32.
  assign w_u = {i_instr[31:12], 12'b0};

  // Select and assemble the immediate; illegal codes yield zero.
  always_comb begin
    o_immext  = '0;
    o_illegal = is_illegal_immsrc(i_immsrc);
    case (i_immsrc)
      IMM_I:   o_immext = {{(XLEN-12){w_s}}, i_instr[31:20]};
      IMM_S:   o_immext = {{(XLEN-12){w_s}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   o_immext = {{(XLEN-12){w_s}}, i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
      IMM_J:   o_immext = {{(XLEN-20){w_s}}, i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
      IMM_U:   o_immext = XLEN'($signed(w_u));
      IMM_Z:   o_immext = XLEN'(i_instr[19:15]);
      default: o_immext = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: decode on the input side, one output
// register stage backed by a one-entry skid buffer, illegal-select counter.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  imm_ext_pipe_if.slave bus
);

  logic [XLEN-1:0]  w_dec_immext;
  logic             w_dec_illegal;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_out;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_immext;
  logic             r_out_illegal;
  logic [TAG_W-1:0] r_out_tag;

  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_immext;
  logic             r_skid_illegal;
  logic [TAG_W-1:0] r_skid_tag;

  logic [CNT_W-1:0] r_illegal_cnt;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_instr   (bus.in_instr),
    .i_immsrc  (bus.in_immsrc),
    .o_immext  (w_dec_immext),
    .o_illegal (w_dec_illegal)
  );

  assign w_accept   = bus.in_valid & ~r_skid_valid;
  assign w_drain    = r_out_valid & bus.out_ready;
  // Output stage takes new data whenever it is empty or emptying.
  assign w_load_out = ~r_out_valid | w_drain;

  // Output-stage register: skid entry has priority over a fresh result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_immext  <= '0;
      r_out_illegal <= 1'b0;
      r_out_tag     <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load_out) begin
      r_out_valid <= r_skid_valid | w_accept;
      if (r_skid_valid) begin
        r_out_immext  <= r_skid_immext;
        r_out_illegal <= r_skid_illegal;
        r_out_tag     <= r_skid_tag;
      end else if (w_accept) begin
        r_out_immext  <= w_dec_immext;
        r_out_illegal <= w_dec_illegal;
        r_out_tag     <= bus.in_tag;
      end
    end
  end

  // Skid register: catches an accept while the output stage is stalled,
  // empties as soon as the output stage drains into it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_valid   <= 1'b0;
      r_skid_immext  <= '0;
      r_skid_illegal <= 1'b0;
      r_skid_tag     <= '0;
    end else if (bus.flush) begin
      r_skid_valid <= 1'b0;
    end else if (w_load_out) begin
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_skid_valid   <= 1'b1;
      r_skid_immext  <= w_dec_immext;
      r_skid_illegal <= w_dec_illegal;
      r_skid_tag     <= bus.in_tag;
    end
  end

  // Saturating count of accepted illegal selects; flushed accepts don't count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_illegal_cnt <= '0;
    else if (w_accept && !bus.flush && w_dec_illegal && (r_illegal_cnt != '1))
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
  end

  assign bus.in_ready    = ~r_skid_valid;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_immext  = r_out_immext;
  assign bus.out_illegal = r_out_illegal;
  assign bus.out_tag     = r_out_tag;
  assign bus.illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: XLEN=64 and XLEN=32 instances driven in lockstep,
// checked against a two-deep FIFO model and an arithmetic immediate model.
module tb_imm_ext_pipe;
  localparam int TAG_W = 5;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0]      ins;
    logic [2:0]       src;
    logic [TAG_W-1:0] tag;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic [31:0]      in_ins    = '0;
  logic [2:0]       in_src    = '0;
  logic [TAG_W-1:0] in_tag    = '0;
  logic             out_ready = 1'b0;
  logic             flush     = 1'b0;

  imm_ext_pipe_if #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CNT_W)) if64();
  imm_ext_pipe_if #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) if32();

  assign if64.flush = flush;      assign if32.flush = flush;
  assign if64.in_valid = in_valid; assign if32.in_valid = in_valid;
  assign if64.in_instr = in_ins[31:7]; assign if32.in_instr = in_ins[31:7];
  assign if64.in_immsrc = in_src; assign if32.in_immsrc = in_src;
  assign if64.in_tag = in_tag;    assign if32.in_tag = in_tag;
  assign if64.out_ready = out_ready; assign if32.out_ready = out_ready;

  imm_ext_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CNT_W)) u64 (
    .clk(clk), .reset(rst), .bus(if64));
  imm_ext_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) u32 (
    .clk(clk), .reset(rst), .bus(if32));

  int n_assert = 0;
  int n_fail   = 0;

  req_t             mq[$];
  int               m_cnt = 0;
  logic [TAG_W-1:0] obs_tags[$];

  // Immediate value from the field rules, as a signed number then wrapped.
  function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] src, int xlen);
    longint v;
    case (src)
      3'd0: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
      3'd1: begin v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                  if (v >= 2048) v -= 4096; end
      3'd2: begin v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                      longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                  if (v >= 4096) v -= 8192; end
      3'd3: begin v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                      longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                  if (v >= 1048576) v -= 2097152; end
      3'd4: begin v = longint'(ins[31:12]) * 4096;
                  if (xlen == 64 && ins[31]) v -= 64'sd4294967296; end
      3'd5: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    return (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready64", 64'(if64.in_ready), 64'(mq.size() < 2));
    chk("in_ready32", 64'(if32.in_ready), 64'(mq.size() < 2));
    chk("out_valid64", 64'(if64.out_valid), 64'(mq.size() > 0));
    chk("out_valid32", 64'(if32.out_valid), 64'(mq.size() > 0));
    chk("cnt64", 64'(if64.illegal_cnt), 64'(m_cnt));
    chk("cnt32", 64'(if32.illegal_cnt), 64'(m_cnt));
    if (mq.size() > 0) begin
      chk("immext64", if64.out_immext, ref_imm(mq[0].ins, mq[0].src, 64));
      chk("immext32", 64'(if32.out_immext), ref_imm(mq[0].ins, mq[0].src, 32));
      chk("illegal", 64'(if64.out_illegal), 64'(mq[0].src >= 3'd6));
      chk("illegal32", 64'(if32.out_illegal), 64'(mq[0].src >= 3'd6));
      chk("tag", 64'(if64.out_tag), 64'(mq[0].tag));
      chk("tag32", 64'(if32.out_tag), 64'(mq[0].tag));
    end
  endtask

  // One clock: model advances on the edge, DUT checked 1 time unit later.
  task automatic step(output bit acc);
    bit drn;
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    if (if64.out_valid && out_ready) obs_tags.push_back(if64.out_tag);
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{ins: in_ins, src: in_src, tag: in_tag});
        if (in_src >= 3'd6 && m_cnt < CMAX) m_cnt++;
      end
    end
    #1 check_all();
  endtask

  task automatic single(logic [31:0] ins, logic [2:0] src, string tag,
                        logic [63:0] exp64, logic [31:0] exp32);
    bit a;
    in_valid = 1'b1; in_ins = ins; in_src = src; out_ready = 1'b1;
    step(a);
    chk({tag, "_64"}, if64.out_immext, exp64);
    chk({tag, "_32"}, 64'(if32.out_immext), 64'(exp32));
    in_valid = 1'b0;
    step(a);
  endtask

  initial begin
    bit a;
    int sent;
    int c0;

    #2 check_all();
    chk("rst_immext", if64.out_immext, 64'd0);
    chk("rst_tag", 64'(if64.out_tag), 64'd0);
    #10 rst = 1'b0;
    @(negedge clk);

    single(32'hFFF0_0000, 3'd0, "I_ffff", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
    single(32'h8000_0000, 3'd4, "U_neg",  64'hFFFF_FFFF_8000_0000, 32'h8000_0000);
    single(32'h000F_8000, 3'd5, "Z_1f",   64'h1F, 32'h1F);
    single(32'hFE00_0FE3, 3'd2, "B_m2",   64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFE);
    single(32'h7FFF_FFFF, 3'd3, "J_pos",  64'h000F_FFFE, 32'h000F_FFFE);
    single(32'h8000_0F80, 3'd1, "S_neg",  64'hFFFF_FFFF_FFFF_F81F, 32'hFFFF_F81F);

    // Back-pressure: four back-to-back requests, downstream stalled 3 cycles.
    obs_tags.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_src = 3'd0; sent = 0;
    for (int i = 0; i < 3; i++) begin
      in_tag = TAG_W'(sent); in_ins = $urandom;
      step(a);
      if (a) sent++;
      if (i == 1) chk("bp_ready_low", 64'(if64.in_ready), 64'd0);
    end
    chk("bp_accepts", 64'(sent), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = (sent < 4); in_tag = TAG_W'(sent); in_ins = $urandom;
      step(a);
      if (a) sent++;
    end
    chk("bp_count", 64'(obs_tags.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("bp_order", (i < obs_tags.size()) ? 64'(obs_tags[i]) : 64'hDEAD, 64'(i));

    // Flush with both stages full and a request on the input.
    out_ready = 1'b0; in_valid = 1'b1; in_src = 3'd6;
    step(a); step(a);
    chk("fl_full", 64'(if64.in_ready), 64'd0);
    c0 = m_cnt;
    flush = 1'b1; in_valid = 1'b1; in_src = 3'd7;
    step(a);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(if64.out_valid), 64'd0);
    chk("fl_ready", 64'(if64.in_ready), 64'd1);
    chk("fl_cnt", 64'(if64.illegal_cnt), 64'(c0));
    out_ready = 1'b1;
    step(a);
    chk("fl_nodrop", 64'(if64.out_valid), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      in_ins    = $urandom;
      in_src    = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
      step(a);
    end
    flush = 1'b0;

    // Reset mid-burst: fill, then assert reset between edges.
    out_ready = 1'b0; in_valid = 1'b1; in_src = 3'd6;
    step(a); step(a);
    #2 rst = 1'b1;
    #1;
    mq.delete(); m_cnt = 0;
    check_all();
    chk("mr_immext", if64.out_immext, 64'd0);
    chk("mr_illegal", 64'(if64.out_illegal), 64'd0);
    chk("mr_tag", 64'(if64.out_tag), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Illegal select 300 times: counter saturates.
    out_ready = 1'b1; in_valid = 1'b1; in_src = 3'd6;
    for (int i = 0; i < 300; i++) begin
      in_ins = $urandom; in_tag = TAG_W'(i);
      step(a);
    end
    chk("sat_cnt", 64'(if64.illegal_cnt), 64'd255);
    chk("sat_immext", if64.out_immext, 64'd0);
    chk("sat_illegal", 64'(if64.out_illegal), 64'd1);
    in_valid = 1'b0;
    step(a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate extender for the decode stage. It accepts the instruction field `instr[31:7]` and an immediate-select code, and produces the sign- or zero-extended immediate at XLEN width. Results pass through a one-stage output register backed by a skid buffer, using valid/ready handshakes on both sides. It adds a CSR zero-extended immediate type, an illegal-select flag and counter, a sideband tag, and flush.

## Interface
- `XLEN`, default 32; datapath width, legal values 32 or 64.
- `TAG_W`, default 5; width of the sideband tag carried alongside each immediate (e.g. rd index).
- `CNT_W`, default 8; width of the saturating illegal-select counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; drops all buffered entries.
- `in_valid`  in  1  upstream holds a valid request.
- `in_ready`  out  1  block can accept a request this cycle.
- `in_instr`  in  25  instruction bits [31:7].
- `in_immsrc`  in  3  immediate type select.
- `in_tag`  in  TAG_W  sideband, returned unchanged.
- `out_valid`  out  1  `out_*` holds a valid result.
- `out_ready`  in  1  downstream accepts the result.
- `out_immext`  out  XLEN  extended immediate.
- `out_illegal`  out  1  `in_immsrc` was an undefined code.
- `out_tag`  out  TAG_W  tag of the current result.
- `illegal_cnt`  out  CNT_W  saturating count of accepted illegal requests.

## Operation
- Immediate encoding, with `s` = `instr[31]` replicated to fill XLEN:
  - 000 I: s, `instr[31:20]`.
  - 001 S: s, `instr[31:25]`, `instr[11:7]`.
  - 010 B: s, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0.
  - 011 J: s, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0.
  - 100 U: s (upper XLEN-32 bits only), `instr[31:12]`, twelve zeros.
  - 101 Z: zero-extended `instr[19:15]` (CSR uimm).
  - 110 and 111 are illegal: `immext` = 0 and `illegal` = 1.
- At XLEN=32 the U result equals `{instr[31:12],12'b0}`; at XLEN=64 it is sign-extended from bit 31.
- The result is computed combinationally, then registered into the output stage (`out_*`).
- Skid buffer:
  - `in_ready` = NOT `skid_valid`.
  - Accept = `in_valid` AND `in_ready`.
  - If accept occurs while the output stage is full and not draining, the computed result goes into the skid register.
  - When the output stage drains (`out_valid` AND `out_ready`), the skid entry, if any, moves to the output stage. Otherwise a newly accepted result loads directly.
- Ordering is strictly FIFO; no entry is lost or duplicated.
- `illegal_cnt` increments on each accepted illegal request, saturates at all-ones, and is cleared only by reset.
- `flush`:
  - Clears `out_valid` and `skid_valid` next edge.
  - Any same-cycle accept is dropped and is not counted.
  - `illegal_cnt` is unaffected.

## Timing
- Reset values:
  - `out_valid` = 0, skid empty, `in_ready` = 1.
  - `out_immext` = 0, `out_illegal` = 0, `out_tag` = 0, `illegal_cnt` = 0.
- Latency: a request accepted at edge N appears on `out_*` after edge N.
- Throughput: 1 result per cycle while `out_ready` = 1.
- Back-pressure:
  - One extra request is absorbed after `out_ready` falls.
  - `in_ready` drops the cycle after the skid fills.
  - `in_ready` returns 1 the cycle after the skid drains.
- `out_*` hold stable while `out_valid` = 1 AND `out_ready` = 0.
- Simultaneous drain and accept with the skid empty: the output stage reloads with the new result; no bubble.
- Asserting reset mid-stream clears all state immediately (asynchronous). Entries in flight are discarded.

## Structure
- Shared package `imm_pkg`:
  - `immsrc` encoding constants: `IMM_I`, `IMM_S`, `IMM_B`, `IMM_J`, `IMM_U`, `IMM_Z`.
  - Function `is_illegal_immsrc`.
- Sub-module `imm_decode`: combinational, parametrised by XLEN; maps instr and immsrc to immext and illegal. It is instantiated once, on the input side.
- The top level holds the output register, skid register, handshake and counter.

## Test plan
- XLEN=32, I-type, instr[31:20]=0xFFF, immsrc=000 → `out_immext` = 0xFFFFFFFF one cycle later.
- XLEN=64, U-type, instr[31:12]=0x80000 → `out_immext` = 0xFFFFFFFF80000000; Z-type with instr[19:15]=0x1F → 0x1F.
- B-type, instr=0x FE000FE3 (bits [31:7]) → 0xFFFFFFFE. J-type with instr[31]=0, all other bits set → 0x000FFFFE.
- Back-pressure: send 4 back-to-back requests, hold `out_ready`=0 for 3 cycles → `in_ready` falls after 2 accepts. Releasing `out_ready` yields tags in order 0,1,2,3 with no loss.
- immsrc=110 repeated 300 times, `CNT_W`=8 → `out_illegal`=1 and `out_immext`=0 each time; `illegal_cnt` saturates at 255.
- Flush with both stages full and `in_valid`=1 → `out_valid`=0 and `in_ready`=1 next cycle; the dropped request is neither output nor counted. Reset asserted mid-burst → all outputs at reset values immediately.
